// File: rtl/conan_pkg.sv
// Shared definitions for the involuntary-message channel arbiter:
// parameter defaults and the arbiter state encoding.
package conan_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int MAX_HOLD_DEF = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/invol_arbiter_rr_prio.sv
// Round-robin pick: first eligible unit at or after ptr, wrapping around.
module rr_prio
    import conan_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         elig,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         onehot,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IDXW = $clog2(NREQ);

    // scan NREQ slots starting at ptr; the first hit wins
    always_comb begin
        int  j;
        logic hit;
        onehot = {NREQ{1'b0}};
        idx    = {IDXW{1'b0}};
        any    = 1'b0;
        j      = 0;
        hit    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j         = (int'(ptr) + k) % NREQ;
            hit       = !any && elig[j];
            onehot[j] = hit;
            idx       = hit ? IDXW'(j) : idx;
            any       = any | elig[j];
        end
    end

endmodule

// File: rtl/invol_arbiter.sv
// Arbiter for the shared involuntary-message channel: round-robin grant,
// one-cycle registered forwarding of the owner's words, hold watchdog.
module invol_arbiter
    import conan_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         grant,
    input  logic [NREQ*32-1:0]      param_data,
    input  logic [NREQ-1:0]         param_write,
    output logic [31:0]             out_data,
    output logic                    out_write,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic [$clog2(NREQ)-1:0] out_src,
    output logic                    err_timeout,
    output logic                    err_stray,
    input  logic                    err_clr
);

    localparam int              IDXW      = $clog2(NREQ);
    localparam logic [15:0]     HOLD_LAST = 16'(MAX_HOLD - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NREQ - 1);

    state_e            state_r, state_s;
    logic [NREQ-1:0]   grant_r, grant_s, mask_r, mask_s;
    logic [31:0]       out_data_r, out_data_s;
    logic              out_write_r, out_write_s, out_sop_r, out_sop_s, out_eop_r, out_eop_s;
    logic              sop_pend_r, sop_pend_s;
    logic              err_timeout_r, err_timeout_s, err_stray_r, err_stray_s;
    logic [IDXW-1:0]   out_src_r, out_src_s, rr_ptr_r, rr_ptr_s, rr_next_s;
    logic [15:0]       hold_r, hold_s;
    logic [NREQ-1:0]   elig_s, pick_oh_s, legal_wr_s;
    logic [IDXW-1:0]   pick_idx_s;
    logic              pick_any_s, src_write_s, src_req_s, stray_s;
    logic [31:0]       src_data_s;

    assign elig_s      = req & ~mask_r;
    assign src_data_s  = param_data[32*out_src_r +: 32];
    assign src_write_s = param_write[out_src_r];
    assign src_req_s   = req[out_src_r];
    assign rr_next_s   = (out_src_r == IDX_LAST) ? {IDXW{1'b0}} : out_src_r + IDXW'(1);
    // only the owner's strobe is legal, and only while it actually holds the grant
    assign legal_wr_s  = (state_r == ST_GRANT) ? grant_r : {NREQ{1'b0}};
    assign stray_s     = |(param_write & ~legal_wr_s);

    rr_prio #(.NREQ(NREQ)) u_rr_prio (
        .elig   (elig_s),
        .ptr    (rr_ptr_r),
        .onehot (pick_oh_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // next-state and next-output decode
    always_comb begin
        state_s       = state_r;
        grant_s       = grant_r;
        mask_s        = mask_r & req;
        out_data_s    = out_data_r;
        out_write_s   = 1'b0;
        out_sop_s     = 1'b0;
        out_eop_s     = 1'b0;
        sop_pend_s    = sop_pend_r;
        out_src_s     = out_src_r;
        rr_ptr_s      = rr_ptr_r;
        hold_s        = hold_r;
        err_timeout_s = err_timeout_r & ~err_clr;
        err_stray_s   = (err_stray_r & ~err_clr) | stray_s;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_s    = pick_oh_s;
                    out_src_s  = pick_idx_s;
                    hold_s     = 16'd0;
                    sop_pend_s = 1'b1;
                    state_s    = ST_GRANT;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (src_write_s) begin
                    out_data_s  = src_data_s;
                    out_write_s = 1'b1;
                    out_sop_s   = sop_pend_r;
                    sop_pend_s  = 1'b0;
                end else begin
                    out_write_s = 1'b0;
                end
                // a voluntary release takes precedence over the watchdog
                if (!src_req_s) begin
                    grant_s  = {NREQ{1'b0}};
                    rr_ptr_s = rr_next_s;
                    state_s  = ST_GAP;
                end else if (hold_r == HOLD_LAST) begin
                    grant_s       = {NREQ{1'b0}};
                    mask_s        = mask_s | grant_r;
                    err_timeout_s = 1'b1;
                    state_s       = ST_GAP;
                end else begin
                    hold_s = hold_r + 16'd1;
                end
            end
            ST_GAP: begin
                out_eop_s = 1'b1;
                state_s   = ST_IDLE;
            end
            default: begin
                grant_s = {NREQ{1'b0}};
                state_s = ST_IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            grant_r       <= {NREQ{1'b0}};
            mask_r        <= {NREQ{1'b0}};
            out_data_r    <= 32'd0;
            out_write_r   <= 1'b0;
            out_sop_r     <= 1'b0;
            out_eop_r     <= 1'b0;
            sop_pend_r    <= 1'b0;
            out_src_r     <= {IDXW{1'b0}};
            rr_ptr_r      <= {IDXW{1'b0}};
            hold_r        <= 16'd0;
            err_timeout_r <= 1'b0;
            err_stray_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            grant_r       <= grant_s;
            mask_r        <= mask_s;
            out_data_r    <= out_data_s;
            out_write_r   <= out_write_s;
            out_sop_r     <= out_sop_s;
            out_eop_r     <= out_eop_s;
            sop_pend_r    <= sop_pend_s;
            out_src_r     <= out_src_s;
            rr_ptr_r      <= rr_ptr_s;
            hold_r        <= hold_s;
            err_timeout_r <= err_timeout_s;
            err_stray_r   <= err_stray_s;
        end
    end

    assign grant       = grant_r;
    assign out_data    = out_data_r;
    assign out_write   = out_write_r;
    assign out_sop     = out_sop_r;
    assign out_eop     = out_eop_r;
    assign out_src     = out_src_r;
    assign err_timeout = err_timeout_r;
    assign err_stray   = err_stray_r;

endmodule
